// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

  // Transaction sequencing states.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    WAIT_RD = 2'b10,
    RESP    = 2'b11
  } arb_state_e;

  // Which requester owns the in-flight transaction.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_D    = 2'b10
  } arb_owner_e;

  // Access size encodings on d_size_i / mem_size_o.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the
// data stage, one outstanding transaction at a time, with a streak counter
// that stops back-to-back data traffic from starving fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  input  logic            if_kill_i,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  input  logic [1:0]      d_size_i,
  output logic            d_done_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [1:0]      mem_size_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  arb_state_e      state_r;
  arb_owner_e      owner_r;
  logic [SW-1:0]   streak_r;
  logic            kill_pend_r;
  logic            if_rvalid_r;
  logic [XLEN-1:0] if_rdata_r;
  logic            d_done_r;
  logic [XLEN-1:0] d_rdata_r;
  logic            mem_req_r;
  logic            mem_we_r;
  logic [XLEN-1:0] mem_addr_r;
  logic [XLEN-1:0] mem_wdata_r;
  logic [1:0]      mem_size_r;

  logic            if_elig_s;
  logic            pick_if_s;
  logic            pick_d_s;
  logic            kill_now_s;

  assign if_elig_s  = if_req_i & ~if_kill_i;
  assign kill_now_s = (owner_r == OWN_IF) & if_kill_i;

  // Winner selection: data by default, fetch when it has been starved long enough.
  always_comb begin
    pick_if_s = 1'b0;
    pick_d_s  = 1'b0;
    if (d_req_i && !(if_elig_s && (streak_r == STREAK_MAX))) begin
      pick_d_s = 1'b1;
    end else if (if_elig_s) begin
      pick_if_s = 1'b1;
    end else begin
      pick_if_s = 1'b0;
      pick_d_s  = 1'b0;
    end
  end

  // Transaction FSM with owner, streak, kill flag and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= OWN_NONE;
      streak_r    <= '0;
      kill_pend_r <= 1'b0;
      if_rvalid_r <= 1'b0;
      if_rdata_r  <= '0;
      d_done_r    <= 1'b0;
      d_rdata_r   <= '0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_size_r  <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_d_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= d_we_i;
            mem_addr_r  <= d_addr_i;
            mem_wdata_r <= d_wdata_i;
            mem_size_r  <= d_size_i;
            owner_r     <= OWN_D;
            state_r     <= REQ;
            if (!if_req_i) begin
              streak_r <= '0;
            end else if (streak_r != STREAK_MAX) begin
              streak_r <= streak_r + SW'(1);
            end
          end else if (pick_if_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= if_addr_i;
            mem_wdata_r <= '0;
            mem_size_r  <= SIZE_D;
            owner_r     <= OWN_IF;
            streak_r    <= '0;
            state_r     <= REQ;
          end
        end
        REQ: begin
          if (kill_now_s) begin
            kill_pend_r <= 1'b1;
          end
          if (mem_gnt_i) begin
            mem_req_r <= 1'b0;
            if (mem_we_r) begin
              d_done_r <= 1'b1;
              state_r  <= RESP;
            end else begin
              state_r <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (kill_now_s) begin
            kill_pend_r <= 1'b1;
          end
          if (mem_rvalid_i) begin
            state_r <= RESP;
            if (owner_r == OWN_IF) begin
              if_rdata_r  <= mem_rdata_i;
              if_rvalid_r <= ~(kill_pend_r | if_kill_i);
            end else begin
              d_rdata_r <= mem_rdata_i;
              d_done_r  <= 1'b1;
            end
          end
        end
        RESP: begin
          if_rvalid_r <= 1'b0;
          d_done_r    <= 1'b0;
          kill_pend_r <= 1'b0;
          owner_r     <= OWN_NONE;
          state_r     <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          owner_r     <= OWN_NONE;
          kill_pend_r <= 1'b0;
          mem_req_r   <= 1'b0;
          if_rvalid_r <= 1'b0;
          d_done_r    <= 1'b0;
        end
      endcase
    end
  end

  // A flush arriving in the response cycle itself still suppresses the fetch pulse.
  assign if_rvalid_o = if_rvalid_r & ~if_kill_i;
  assign if_rdata_o  = if_rdata_r;
  assign d_done_o    = d_done_r;
  assign d_rdata_o   = d_rdata_r;
  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign mem_size_o  = mem_size_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory responder whose
// grant and read-data delays are set per test.
module tb_mem_port_arbiter;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req_i, if_kill_i, if_rvalid_o;
  logic [XLEN-1:0] if_addr_i, if_rdata_o;
  logic            d_req_i, d_we_i, d_done_o;
  logic [XLEN-1:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [1:0]      d_size_i;
  logic            mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [XLEN-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [1:0]      mem_size_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Responder configuration: cycles of mem_req_o without grant, cycles of waiting before rvalid.
  int              gnt_wait = 0;
  int              rv_wait  = 0;
  logic [XLEN-1:0] rd_data  = '0;
  bit              rd_pend  = 1'b0;
  int              g_cnt    = 0;
  int              rd_cnt   = 0;

  // Monitor state.
  int              if_cnt = 0, d_cnt = 0, req_rises = 0, req_rise_cyc = 0, req_len = 0, unstable = 0;
  logic [XLEN-1:0] cap_addr = '0, cap_wdata = '0;
  logic            cap_we = 1'b0;
  logic [1:0]      cap_size = 2'b00;
  logic            prev_req = 1'b0;

  int exp3 [6] = '{2, 2, 2, 2, 1, 2};
  int k, c, n, dc, i0, d0, r1, u0;

  mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_size_i(d_size_i), .d_done_o(d_done_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Cycle counter used as the time base for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder, driven between edges.
  always @(negedge clk) begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = rd_data;
    if (rst) begin
      rd_pend = 1'b0;
      g_cnt   = 0;
      rd_cnt  = 0;
    end else if (rd_pend) begin
      if (rd_cnt == rv_wait) begin
        mem_rvalid_i = 1'b1;
        rd_pend      = 1'b0;
      end else begin
        rd_cnt++;
      end
    end else if (mem_req_o) begin
      if (g_cnt == gnt_wait) begin
        mem_gnt_i = 1'b1;
        g_cnt     = 0;
        if (!mem_we_o) begin
          rd_pend = 1'b1;
          rd_cnt  = 0;
        end
      end else begin
        g_cnt++;
      end
    end
  end

  // Pulse counters and request-phase capture/stability tracking.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_rvalid_o) if_cnt++;
      if (d_done_o) d_cnt++;
      if (mem_req_o && !prev_req) begin
        req_rises++;
        req_rise_cyc = cyc;
        req_len      = 1;
        cap_addr     = mem_addr_o;
        cap_wdata    = mem_wdata_o;
        cap_we       = mem_we_o;
        cap_size     = mem_size_o;
      end else if (mem_req_o) begin
        req_len++;
        if (mem_addr_o != cap_addr || mem_wdata_o != cap_wdata ||
            mem_we_o != cap_we || mem_size_o != cap_size) unstable++;
      end
    end
    prev_req = mem_req_o;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the next completion pulse; kind 1 = fetch, 2 = data, 0 = timeout.
  task automatic wait_any(input int maxc, output int kind, output int cy);
    kind = 0;
    cy   = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      #1;
      if (if_rvalid_o) begin
        kind = 1;
        cy   = cyc;
        break;
      end
      if (d_done_o) begin
        kind = 2;
        cy   = cyc;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req_i = 1'b0; if_kill_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_size_i = 2'b00;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 64'(mem_req_o), 64'd0);
    check("rst_mem_addr", mem_addr_o, 64'd0);
    check("rst_if_rvalid", 64'(if_rvalid_o), 64'd0);
    check("rst_d_done", 64'(d_done_o), 64'd0);
    check("rst_mem_size", 64'(mem_size_o), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Lone fetch, immediate grant and data.
    n = cyc; d0 = d_cnt;
    if_req_i = 1'b1; if_addr_i = 64'h1000; rd_data = 64'h13;
    wait_any(20, k, c);
    check("t1_kind", 64'(k), 64'd1);
    check("t1_pulse_lat", 64'(c - n), 64'd3);
    check("t1_req_lat", 64'(req_rise_cyc - n), 64'd1);
    check("t1_rdata", if_rdata_o, 64'h13);
    check("t1_addr", cap_addr, 64'h1000);
    check("t1_size", 64'(cap_size), 64'd3);
    tick();
    if_req_i = 1'b0;
    repeat (3) tick();
    check("t1_no_done", 64'(d_cnt - d0), 64'd0);

    // Simultaneous fetch and store: store first, fetch after one idle cycle.
    n = cyc;
    if_req_i = 1'b1; if_addr_i = 64'h1008;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 64'h2008; d_wdata_i = 64'hDEAD; d_size_i = 2'b10;
    wait_any(20, k, c);
    check("t2_kind_d", 64'(k), 64'd2);
    check("t2_store_lat", 64'(c - n), 64'd2);
    check("t2_we", 64'(cap_we), 64'd1);
    check("t2_size", 64'(cap_size), 64'd2);
    check("t2_addr", cap_addr, 64'h2008);
    check("t2_wdata", cap_wdata, 64'hDEAD);
    dc = c;
    tick();
    d_req_i = 1'b0; d_we_i = 1'b0;
    wait_any(20, k, c);
    check("t2_kind_if", 64'(k), 64'd1);
    check("t2_if_req_gap", 64'(req_rise_cyc - dc), 64'd2);
    check("t2_if_pulse_gap", 64'(c - dc), 64'd4);
    check("t2_if_addr", cap_addr, 64'h1008);
    tick();
    if_req_i = 1'b0;
    repeat (3) tick();

    // Starvation limit: four loads, then the fetch, then data resumes.
    if_req_i = 1'b1; if_addr_i = 64'h3000;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h3100; rd_data = 64'h100;
    for (int i = 0; i < 6; i++) begin
      wait_any(30, k, c);
      check($sformatf("t3_seq%0d", i), 64'(k), 64'(exp3[i]));
      if (k == 2) check($sformatf("t3_drd%0d", i), d_rdata_o, rd_data);
      else if (k == 1) check("t3_ird", if_rdata_o, rd_data);
      tick();
      if (k == 2) d_addr_i = d_addr_i + 64'd8;
      if (k == 1) if_req_i = 1'b0;
      rd_data = rd_data + 64'd1;
    end
    d_req_i = 1'b0;
    repeat (3) tick();

    // Slow memory: three request cycles held stable, data two cycles late.
    gnt_wait = 2; rv_wait = 2;
    u0 = unstable; i0 = if_cnt; n = cyc;
    if_req_i = 1'b1; if_addr_i = 64'h4000; rd_data = 64'h44;
    wait_any(30, k, c);
    check("t4_kind", 64'(k), 64'd1);
    check("t4_lat", 64'(c - n), 64'd7);
    check("t4_req_len", 64'(req_len), 64'd3);
    check("t4_stable", 64'(unstable - u0), 64'd0);
    check("t4_rdata", if_rdata_o, 64'h44);
    tick();
    if_req_i = 1'b0;
    repeat (5) tick();
    check("t4_one_pulse", 64'(if_cnt - i0), 64'd1);
    gnt_wait = 0; rv_wait = 0;

    // Kill during WAIT_RD: silent completion, then a data load is served.
    rv_wait = 3;
    i0 = if_cnt; n = cyc;
    if_req_i = 1'b1; if_addr_i = 64'h5000; rd_data = 64'h55;
    repeat (3) tick();
    if_kill_i = 1'b1; if_req_i = 1'b0;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h6000;
    tick();
    if_kill_i = 1'b0;
    repeat (2) tick();
    rd_data = 64'h66;
    wait_any(30, k, c);
    check("t5_kind", 64'(k), 64'd2);
    check("t5_d_lat", 64'(c - n), 64'd13);
    check("t5_d_rdata", d_rdata_o, 64'h66);
    check("t5_d_addr", cap_addr, 64'h6000);
    tick();
    d_req_i = 1'b0;
    r1 = req_rises;
    repeat (6) tick();
    check("t5_no_reissue", 64'(req_rises - r1), 64'd0);
    check("t5_no_if_pulse", 64'(if_cnt - i0), 64'd0);
    rv_wait = 0;

    // Asynchronous reset in WAIT_RD abandons the fetch.
    rv_wait = 3;
    i0 = if_cnt; d0 = d_cnt;
    if_req_i = 1'b1; if_addr_i = 64'h7000;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("t6_addr_async", mem_addr_o, 64'd0);
    check("t6_req_async", 64'(mem_req_o), 64'd0);
    if_req_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();
    repeat (8) tick();
    check("t6_no_if_pulse", 64'(if_cnt - i0), 64'd0);
    check("t6_no_d_pulse", 64'(d_cnt - d0), 64'd0);
    rv_wait = 0;
    n = cyc;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 64'h8000; d_wdata_i = 64'h55; d_size_i = 2'b01;
    wait_any(20, k, c);
    check("t6_kind", 64'(k), 64'd2);
    check("t6_store_lat", 64'(c - n), 64'd2);
    check("t6_size", 64'(cap_size), 64'd1);
    check("t6_addr", cap_addr, 64'h8000);
    tick();
    d_req_i = 1'b0; d_we_i = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
